// File: rtl/keypad_matrix_emu.sv
// 4x4 keypad contact model with programmable bounce on press and release.
// Optional AUTO_RELEASE_EN: held key releases itself after HOLD_CYCLES.
module keypad_matrix_emu #(
  parameter int BOUNCE_TOGGLES = 2,
  parameter int BOUNCE_PERIOD  = 3,
  parameter int HOLD_CYCLES    = 200,
  parameter int CNT_W          = 16
) (
  input  logic       Clk1,
  input  logic       Rst_n,
  input  logic [3:0] Row,
  output logic [3:0] Column,
  input  logic [3:0] Key_code,
  input  logic       Press_req,
  input  logic       Release_req,
  output logic       Busy,
  output logic       Pressed
);

  typedef enum logic [1:0] {
    IDLE,
    PRESS_BNC,
    HELD,
    REL_BNC
  } state_t;

  localparam int PH_N = 2 * BOUNCE_TOGGLES;
  localparam bit CLEAN = (BOUNCE_TOGGLES == 0);
  localparam logic [CNT_W-1:0] PER_LAST =
    CNT_W'((BOUNCE_PERIOD > 0) ? BOUNCE_PERIOD - 1 : 0);
  localparam logic [CNT_W-1:0] PH_LAST =
    CNT_W'((PH_N > 0) ? PH_N - 1 : 0);
  localparam logic [CNT_W-1:0] HOLD_LAST =
    CNT_W'((HOLD_CYCLES > 0) ? HOLD_CYCLES - 1 : 0);

  state_t           state;
  logic             contact;
  logic [3:0]       key;
  logic [CNT_W-1:0] pcnt;
  logic [CNT_W-1:0] pidx;
  logic [CNT_W-1:0] pidx_nx;
  logic             rel_pend;
  logic             ph_end;
  logic             bnc_done;
  logic             rel_go;

  assign pidx_nx  = pidx + 1'b1;
  assign ph_end   = (pcnt == PER_LAST);
  assign bnc_done = ph_end && (pidx == PH_LAST);

`ifdef AUTO_RELEASE_EN
  logic [CNT_W-1:0] hcnt;
  logic             hold_exp;

  assign hold_exp = (state == HELD) && (hcnt == HOLD_LAST);
  assign rel_go   = Release_req | rel_pend | hold_exp;

  // Restarts on every HELD entry since it idles at 0 outside HELD.
  always_ff @(posedge Clk1 or negedge Rst_n) begin
    if (!Rst_n) begin
      hcnt <= '0;
    end else if (state != HELD) begin
      hcnt <= '0;
    end else if (!hold_exp) begin
      hcnt <= hcnt + 1'b1;
    end
  end
`else
  logic unused_hold;

  assign unused_hold = ^HOLD_LAST;
  assign rel_go      = Release_req | rel_pend;
`endif

  always_ff @(posedge Clk1 or negedge Rst_n) begin
    if (!Rst_n) begin
      state    <= IDLE;
      contact  <= 1'b0;
      key      <= '0;
      pcnt     <= '0;
      pidx     <= '0;
      rel_pend <= 1'b0;
      Busy     <= 1'b0;
      Pressed  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (Press_req) begin
            key      <= Key_code;
            pcnt     <= '0;
            pidx     <= '0;
            rel_pend <= 1'b0;
            contact  <= 1'b1;
            Busy     <= 1'b1;
            if (CLEAN) begin
              state   <= HELD;
              Pressed <= 1'b1;
            end else begin
              state <= PRESS_BNC;
            end
          end
        end
        PRESS_BNC: begin
          if (Release_req) rel_pend <= 1'b1;
          if (ph_end) begin
            pcnt <= '0;
            if (bnc_done) begin
              state   <= HELD;
              pidx    <= '0;
              contact <= 1'b1;
              Pressed <= 1'b1;
            end else begin
              pidx    <= pidx_nx;
              contact <= ~pidx_nx[0];
            end
          end else begin
            pcnt <= pcnt + 1'b1;
          end
        end
        HELD: begin
          if (rel_go) begin
            rel_pend <= 1'b0;
            pcnt     <= '0;
            pidx     <= '0;
            contact  <= 1'b0;
            Pressed  <= 1'b0;
            if (CLEAN) begin
              state <= IDLE;
              Busy  <= 1'b0;
            end else begin
              state <= REL_BNC;
            end
          end
        end
        REL_BNC: begin
          if (ph_end) begin
            pcnt <= '0;
            if (bnc_done) begin
              state   <= IDLE;
              pidx    <= '0;
              contact <= 1'b0;
              Busy    <= 1'b0;
            end else begin
              pidx    <= pidx_nx;
              contact <= pidx_nx[0];
            end
          end else begin
            pcnt <= pcnt + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Zero-latency return path: only the latched column can be pulled low.
  always_comb begin
    Column = 4'b1111;
    if (contact && !Row[key[3:2]]) Column[key[1:0]] = 1'b0;
  end

endmodule
